// File: rtl/serial_adder_pkg.sv
// Shared types and sizing constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

  // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/serial_adder_half_adder_cell.sv
// Combinational half adder; two of these plus an OR make one full-adder slice.
module half_adder_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/serial_adder_core.sv
// Bit-serial unsigned adder: one operand bit per cycle, LSB first.
// Result and carry-out are published only when the last bit completes.
module serial_adder_core
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_part, r_sum;
  logic             r_carry, r_cout;
  logic [CW-1:0]    r_cnt;

  logic             w_s1, w_c1, w_s, w_c2, w_carry, w_last;
  logic [WIDTH-1:0] w_part_nxt;

  // Full adder = two half adders; the carry OR lives here.
  half_adder_cell u_ha0 (.x(r_a[0]), .y(r_b[0]),   .s(w_s1), .c(w_c1));
  half_adder_cell u_ha1 (.x(w_s1),   .y(r_carry),  .s(w_s),  .c(w_c2));

  assign w_carry = w_c1 | w_c2;
  assign w_last  = (r_cnt == LAST);

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign w_part_nxt = (r_part >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

  // Next-state: DONE is a one-cycle pulse back to IDLE; start only matters in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = SHIFT;
      SHIFT:   if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath: capture on accept, shift/add per bit, publish on the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_part  <= w_part_nxt;
          r_carry <= w_carry;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum  <= w_part_nxt;
            r_cout <= w_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_core.sv
// Self-checking bench for serial_adder_core: directed scenarios plus a random
// regression against plain-arithmetic expectations ({cout,sum} = a+b).
module tb_serial_adder_core;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b, sum;
  logic         busy, done, cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One addition with a start pulse; operands are scrambled after acceptance.
  task automatic do_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input string tag);
    logic [W:0] exp;
    int n;
    bit seen;
    exp = {1'b0, xa} + {1'b0, xb};
    a = xa; b = xb; start = 1'b1;
    step();
    start = 1'b0;
    n = 1; seen = 1'b0;
    while (n <= W + 4 && !seen) begin
      a = W'($urandom); b = W'($urandom);
      if (done === 1'b1) seen = 1'b1;
      else begin step(); n++; end
    end
    checks++;
    if (!seen || n != W + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d seen=%0d expected %0d", tag, n, seen, W + 1);
    end
    checks++;
    if ({cout, sum} !== exp) begin
      errors++;
      $display("FAIL %s result a=%0h b=%0h: got %0h expected %0h", tag, xa, xb, {cout, sum}, exp);
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: got busy=%b done=%b expected 0 0", tag, busy, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #1;
    checks++;
    if ({busy, done, cout, sum} !== '0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b cout=%b sum=%0h expected all 0", busy, done, cout, sum);
    end
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    a = 8'h5A; b = 8'h3C; start = 1'b1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic busy c0: got %b expected 0", busy); end
    step();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      checks++;
      if (busy !== (c <= 9)) begin
        errors++; $display("FAIL basic busy c%0d: got %b expected %b", c, busy, (c <= 9));
      end
      checks++;
      if (done !== (c == 9)) begin
        errors++; $display("FAIL basic done c%0d: got %b expected %b", c, done, (c == 9));
      end
      checks++;
      if ({cout, sum} !== ((c >= 9) ? 9'h096 : 9'h000)) begin
        errors++; $display("FAIL basic result c%0d: got %0h expected %0h", c, {cout, sum},
                           (c >= 9) ? 9'h096 : 9'h000);
      end
      step();
    end
  endtask

  task automatic test_overflow();
    do_add(8'hFF, 8'h01, "ovf_ff_01");
    do_add(8'hFF, 8'hFF, "ovf_ff_ff");
    do_add(8'h00, 8'h00, "zero");
  endtask

  // start held high: accepts at cycles 0,10,20,30 only; operands change every cycle.
  task automatic test_back_to_back();
    logic [W-1:0] opa [0:39];
    logic [W-1:0] opb [0:39];
    logic [W:0]   exp;
    for (int i = 0; i < 40; i++) begin
      opa[i] = W'($urandom); opb[i] = W'($urandom);
    end
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      a = opa[c]; b = opb[c];
      checks++;
      if (busy !== ((c % 10) != 0)) begin
        errors++; $display("FAIL b2b busy c%0d: got %b expected %b", c, busy, ((c % 10) != 0));
      end
      checks++;
      if (done !== ((c % 10) == 9)) begin
        errors++; $display("FAIL b2b done c%0d: got %b expected %b", c, done, ((c % 10) == 9));
      end
      if ((c % 10) == 9) begin
        exp = {1'b0, opa[c - 9]} + {1'b0, opb[c - 9]};
        checks++;
        if ({cout, sum} !== exp) begin
          errors++; $display("FAIL b2b result c%0d: got %0h expected %0h", c, {cout, sum}, exp);
        end
      end
      step();
    end
    start = 1'b0;
    step();
  endtask

  // A start pulse during SHIFT must be dropped, not queued.
  task automatic test_ignore_start();
    a = 8'h10; b = 8'h20; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      if (c == 4) begin a = 8'h77; start = 1'b1; end
      else start = 1'b0;
      checks++;
      if (done !== (c == 9)) begin
        errors++; $display("FAIL ignore done c%0d: got %b expected %b", c, done, (c == 9));
      end
      if (c >= 9) begin
        checks++;
        if ({cout, sum} !== 9'h030) begin
          errors++; $display("FAIL ignore result c%0d: got %0h expected 30", c, {cout, sum});
        end
      end
      step();
    end
  endtask

  task automatic test_reset_abort();
    do_add(8'h5A, 8'h3C, "pre_abort");
    a = 8'hC3; b = 8'h81; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 5; c++) step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, cout, sum} !== '0) begin
      errors++;
      $display("FAIL abort immediate: got busy=%b done=%b cout=%b sum=%0h expected all 0",
               busy, done, cout, sum);
    end
    step();
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      checks++;
      if ({busy, done, cout, sum} !== '0) begin
        errors++;
        $display("FAIL abort after c%0d: got busy=%b done=%b cout=%b sum=%0h expected all 0",
                 c, busy, done, cout, sum);
      end
      step();
    end
    do_add(8'hA5, 8'h7E, "post_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) do_add(W'($urandom), W'($urandom), "rand");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_core.md
SERIAL_ADDER_CORE -- requirements
Module: serial_adder_core

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits.
REQ-002 SHALL have port clk  input  1: single rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1: request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH: operand A; captured on the accepting start edge.
REQ-006 SHALL have port b  input  WIDTH: operand B; captured on the accepting start edge.
REQ-007 SHALL have port busy  output  1: high in SHIFT and DONE; low in IDLE.
REQ-008 SHALL have port done  output  1: single-cycle pulse; high only in DONE.
REQ-009 SHALL have port sum  output  WIDTH: registered result of the last completed addition.
REQ-010 SHALL have port cout  output  1: registered carry-out of the last completed addition.

Function
REQ-011 SHALL implement the FSM states IDLE, SHIFT and DONE, all transitions on the rising edge of clk.
REQ-012 IDLE with start=1 SHALL capture a and b into operand shift registers, clear the carry flop and bit counter, and go to SHIFT.
REQ-013 IDLE with start=0 SHALL remain in IDLE with all registers unchanged.
REQ-014 Each SHIFT cycle SHALL add the operand LSBs and the carry flop with a full adder built from two half-adder cells (sum = x^y^c, carry = x&y | c&(x^y)).
REQ-015 Each SHIFT cycle SHALL shift both operand registers right by one, shift the sum bit into the MSB of a partial-result register, store the new carry and increment the counter.
REQ-016 SHIFT SHALL last exactly WIDTH cycles; on the edge that processes bit WIDTH-1 the FSM SHALL load sum from the partial-result register including that bit, load cout from the final carry, and go to DONE.
REQ-017 DONE SHALL last exactly one cycle and then return unconditionally to IDLE.
REQ-018 done SHALL be high exactly WIDTH+1 cycles after the edge that accepted start.
REQ-019 sum and cout SHALL change only on the edge entering DONE and SHALL hold their values through IDLE and the next SHIFT phase.
REQ-020 start asserted in SHIFT or DONE SHALL be ignored and SHALL NOT be queued.
REQ-021 The minimum start-to-start period for back-to-back additions SHALL be WIDTH+2 cycles.
REQ-022 Arithmetic SHALL be unsigned modulo 2^WIDTH, with the overflow bit reported on cout ({cout,sum} = a+b).
REQ-023 a and b changing after the accepting edge SHALL NOT affect the result in progress.

Reset
REQ-024 rst high SHALL immediately force the IDLE state, busy=0, done=0, sum=0, cout=0, counter=0, carry=0, and clear the operand and partial-result registers, independent of clk.
REQ-025 rst asserted mid-SHIFT SHALL abort the operation without updating sum or cout to a partial value.
REQ-026 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-027 A shared package serial_adder_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, DONE), the default WIDTH constant and the counter-width constant $clog2(WIDTH).
REQ-028 The design SHALL contain one sub-module, half_adder_cell (inputs x and y; outputs s = x^y and c = x&y), instantiated twice to form the bit-serial full adder; the carry OR SHALL sit in the parent.
REQ-029 All sequential logic SHALL be in the parent, and half_adder_cell SHALL be purely combinational.

Verification
REQ-030 The bench SHALL check a=0x5A, b=0x3C, start pulse -> done at cycle 9, sum=0x96, cout=0, busy high for cycles 1-9.
REQ-031 The bench SHALL check a=0xFF, b=0x01 -> sum=0x00, cout=1; then a=0xFF, b=0xFF -> sum=0xFE, cout=1.
REQ-032 The bench SHALL check start held high continuously with alternating operands -> one result every 10 cycles, each matching a+b, with no start accepted while busy.
REQ-033 The bench SHALL check start at cycle 0 with a=0x10, b=0x20, then a=0x77 and start pulsed at cycle 4 -> sum=0x30, cout=0, and the second request is not executed.
REQ-034 The bench SHALL check rst asserted asynchronously at cycle 5 of an addition, following a completed result of 0x96 -> busy=0, done=0, sum=0x00, cout=0 immediately, and no done pulse follows.
REQ-035 The bench SHALL run a random regression of 1000 operand pairs -> {cout,sum} equals a+b on every done pulse.
